dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, means the maximum number of cycles spent in REQ+WAIT before a bus error; legal range is 2..255.
REQ-002 Port clock, input, 1, is the single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1, is a synchronous, active-high reset.
REQ-004 Port mem_read, input, 1, is the load request from the MEM stage.
REQ-005 Port mem_write, input, 1, is the store request from the MEM stage; mem_write wins if both are high.
REQ-006 Port funct3, input, 3, is the RISC-V load/store funct3 (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-007 Port addr, input, 32, is the byte address.
REQ-008 Port wdata, input, 32, is the store data, right-aligned.
REQ-009 Port stall, output, 1, freezes the pipeline.
REQ-010 Port rdata, output, 32, is the extended load result, registered.
REQ-011 Port done, output, 1, is a one-cycle completion pulse.
REQ-012 Port misaligned, output, 1, is a one-cycle alignment-exception pulse.
REQ-013 Port bus_err, output, 1, is a one-cycle timeout-error pulse.
REQ-014 Port c_req_valid, output, 1, is the cache request valid.
REQ-015 Port c_req_ready, input, 1, is the cache request accept.
REQ-016 Port c_req_we, output, 1, is 1 for a store.
REQ-017 Port c_req_addr, output, 32, is the word address {addr[31:2],2'b00}.
REQ-018 Port c_req_be, output, 4, is the byte-lane enable.
REQ-019 Port c_req_wdata, output, 32, is the lane-replicated store data.
REQ-020 Port c_resp_valid, input, 1, is the cache response valid.
REQ-021 Port c_resp_data, input, 32, is the cache response word.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-023 In IDLE with mem_read|mem_write and an aligned address, the block SHALL latch we, funct3, addr[1:0], word address, be and lane data, then go to REQ.
REQ-024 Alignment SHALL be checked as follows: H/HU misaligned if addr[0]=1; W misaligned if addr[1:0]!=0; byte accesses are always aligned.
REQ-025 A misaligned request SHALL pulse misaligned for that cycle, issue no cache request, keep stall low and stay in IDLE; it re-pulses each cycle the request persists.
REQ-026 stall SHALL be high when (IDLE and an aligned request) or state is REQ or WAIT; it SHALL be low in DONE.
REQ-027 The be and lane rules SHALL be:
  - byte: be=1<<addr[1:0], byte replicated x4.
  - half: be=4'b0011 if addr[1]=0 else 4'b1100, half replicated x2.
  - word: be=4'b1111, data as given.
  - Loads drive the same be.
REQ-028 In REQ, c_req_valid SHALL be 1 with all c_req_* stable until the cycle c_req_ready=1, then the FSM goes to WAIT; c_req_valid SHALL be 0 in every other state.
REQ-029 c_resp_valid SHALL be ignored outside WAIT, including a late response after a timeout.
REQ-030 In WAIT with c_resp_valid, the FSM SHALL register rdata and go to DONE.
  - Loads: LB/LBU select the byte at latched addr[1:0]; LH/LHU select the half at addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Stores leave rdata unchanged.
REQ-031 DONE SHALL last exactly one cycle with done=1, then go to IDLE; the request inputs SHALL be ignored in DONE.
REQ-032 A timeout counter (8-bit) SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
  - When it equals TIMEOUT-1 with no advancing handshake that cycle, the FSM goes to DONE with bus_err=1, done=1 and rdata=0.
  - A completing handshake in that same cycle takes priority over the timeout.
REQ-033 Minimum load latency SHALL be: accept at cycle 0, c_req_ready at cycle 1, c_resp_valid at cycle 2, done at cycle 3; stall is high for cycles 0-2.

Reset
REQ-034 On reset, the state SHALL be IDLE; stall, done, misaligned, bus_err and c_req_valid SHALL be 0; rdata, counter and latched fields SHALL be 0.
REQ-035 Reset in any state, including mid-REQ or mid-WAIT, SHALL abandon the transaction; c_req_valid is 0 from the cycle after reset is sampled.
REQ-036 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-037 LB at addr 0x103, ready at once, response 0x80FF1234 -> rdata=0xFFFFFF80, done at cycle 3.
REQ-038 LHU at addr 0x102, response 0x80017F00 -> rdata=0x00008001; c_req_addr=0x100, be=4'b1100.
REQ-039 SB at addr 0x101 with wdata 0x000000AB -> c_req_we=1, be=4'b0010, c_req_wdata=0xABABABAB, rdata unchanged.
REQ-040 LW at addr 0x102 -> misaligned pulse, c_req_valid never 1, stall 0.
REQ-041 TIMEOUT=4, c_req_ready held 0 -> bus_err+done at cycle 4, rdata=0; a response injected later is ignored.
REQ-042 Reset asserted in WAIT -> all outputs 0 next cycle; a following LW at 0x200 with response 0x12345678 completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns MEM-stage load/store requests into a
// single-beat cache request/response handshake with alignment and timeout checks.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic        c_req_valid,
  input  logic        c_req_ready,
  output logic        c_req_we,
  output logic [31:0] c_req_addr,
  output logic [3:0]  c_req_be,
  output logic [31:0] c_req_wdata,
  input  logic        c_resp_valid,
  input  logic [31:0] c_resp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  // The counter is compared before its increment lands, so firing at
  // TIMEOUT-2 means the incremented count reaches TIMEOUT-1 in that cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        req;
  logic        is_half;
  logic        is_word;
  logic        aligned;
  logic [3:0]  be_new;
  logic [31:0] lane_new;
  logic        timeout_hit;

  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  assign req         = mem_read | mem_write;
  assign is_word     = funct3[1];
  assign is_half     = (funct3[1:0] == 2'b01);
  assign aligned     = is_word ? (addr[1:0] == 2'b00) : (is_half ? ~addr[0] : 1'b1);
  assign timeout_hit = (cnt_q >= CNT_LAST);

  always_comb begin
    if (is_word) begin
      be_new   = 4'b1111;
      lane_new = wdata;
    end else if (is_half) begin
      be_new   = addr[1] ? 4'b1100 : 4'b0011;
      lane_new = {2{wdata[15:0]}};
    end else begin
      be_new   = 4'b0001 << addr[1:0];
      lane_new = {4{wdata[7:0]}};
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    waddr_d     = waddr_q;
    be_d        = be_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    stall       = 1'b0;
    misaligned  = 1'b0;
    c_req_valid = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (aligned) begin
            stall   = 1'b1;
            we_d    = mem_write;
            f3_d    = funct3;
            off_d   = addr[1:0];
            waddr_d = {addr[31:2], 2'b00};
            be_d    = be_new;
            lane_d  = lane_new;
            cnt_d   = 8'd0;
            state_d = REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        stall       = 1'b1;
        c_req_valid = 1'b1;
        cnt_d       = cnt_q + 8'd1;
        if (c_req_ready) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (c_resp_valid) begin
          if (!we_q) rdata_d = load_ext(f3_q, off_q, c_resp_data);
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      waddr_q <= 32'd0;
      be_q    <= 4'd0;
      lane_q  <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign rdata       = rdata_q;
  assign bus_err     = err_q;
  assign c_req_we    = we_q;
  assign c_req_addr  = waddr_q;
  assign c_req_be    = be_q;
  assign c_req_wdata = lane_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl; expected completions go through a
// scoreboard queue and are popped when the DUT pulses done.
module tb_dmem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] rdata;
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [31:0] c_req_addr, c_req_wdata;
  logic [3:0]  c_req_be;
  logic        c_resp_valid;
  logic [31:0] c_resp_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clock = ~clock;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done),
    .misaligned(misaligned), .bus_err(bus_err),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_be(c_req_be), .c_req_wdata(c_req_wdata),
    .c_resp_valid(c_resp_valid), .c_resp_data(c_resp_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_mis"}, misaligned, 1'b0);
    check({tag, "_berr"}, bus_err, 1'b0);
    check({tag, "_cvalid"}, c_req_valid, 1'b0);
  endtask

  // Cycle 0 is the accepting IDLE cycle; ready/resp are asserted in the
  // given cycle numbers (-1 = never) and done must appear in exp_done.
  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ready_cyc, input int resp_cyc,
                         input logic [31:0] resp_data,
                         input logic [31:0] exp_caddr, input logic [3:0] exp_be,
                         input logic [31:0] exp_cwd, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_done);
    exp_t e;
    exp_t p;
    bit   seen = 1'b0;
    mem_write = we;
    mem_read  = ~we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    check("accept_stall", stall, 1'b1);
    check("accept_mis", misaligned, 1'b0);
    check("accept_cvalid", c_req_valid, 1'b0);
    e.rdata    = exp_rd;
    e.err      = exp_err;
    e.done_cyc = exp_done;
    sb.push_back(e);
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'($urandom_range(7, 0));
    addr      = $urandom;
    wdata     = $urandom;
    for (int k = 1; k <= 20 && !seen; k++) begin
      c_req_ready  = (k == ready_cyc);
      c_resp_valid = (k == resp_cyc);
      c_resp_data  = (k == resp_cyc) ? resp_data : $urandom;
      #1;
      if (k == 1) begin
        check("req_cvalid", c_req_valid, 1'b1);
        check("req_we", c_req_we, we);
        check("req_addr", c_req_addr, exp_caddr);
        check("req_be", c_req_be, exp_be);
        check("req_wdata", c_req_wdata, exp_cwd);
      end
      if (done) begin
        p = sb.pop_front();
        check("done_rdata", rdata, p.rdata);
        check("done_berr", bus_err, p.err);
        check("done_cycle", k, p.done_cyc);
        check("done_stall", stall, 1'b0);
        seen = 1'b1;
      end else begin
        check("busy_stall", stall, 1'b1);
      end
      tick();
    end
    c_req_ready  = 1'b0;
    c_resp_valid = 1'b0;
    check("done_seen", seen, 1'b1);
    if (!seen && sb.size() > 0) void'(sb.pop_front());
    #1;
    check_quiet("after_done");
  endtask

  initial begin
    reset        = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    funct3       = 3'd0;
    addr         = 32'd0;
    wdata        = 32'd0;
    c_req_ready  = 1'b0;
    c_resp_valid = 1'b0;
    c_resp_data  = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_quiet("reset");
    check("reset_rdata", rdata, 32'd0);
    check("reset_caddr", c_req_addr, 32'd0);

    // LB 0x103 -> sign-extended top byte, minimum latency
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 1, 2, 32'h80FF1234,
            32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    // LHU 0x102 -> upper half zero-extended
    run_txn(1'b0, 3'b101, 32'h102, 32'h0, 1, 2, 32'h80017F00,
            32'h100, 4'b1100, 32'h0, 32'h00008001, 1'b0, 3);
    // SB 0x101: byte replicated, rdata untouched by the store response
    run_txn(1'b1, 3'b000, 32'h101, 32'h000000AB, 1, 2, 32'h55555555,
            32'h100, 4'b0010, 32'hABABABAB, 32'h00008001, 1'b0, 3);

    // LW 0x102 and LH 0x103 are misaligned: pulse every cycle, no request
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h102;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mis_pulse", misaligned, 1'b1);
      check("mis_stall", stall, 1'b0);
      check("mis_cvalid", c_req_valid, 1'b0);
      tick();
    end
    funct3 = 3'b001;
    addr   = 32'h103;
    #1;
    check("mis_half", misaligned, 1'b1);
    check("mis_half_stall", stall, 1'b0);
    tick();
    mem_read = 1'b0;
    #1;
    check_quiet("mis_release");

    // Timeout in REQ (ready never), then a late response must be ignored
    run_txn(1'b0, 3'b010, 32'h200, 32'h0, -1, -1, 32'h0,
            32'h200, 4'b1111, 32'h0, 32'h0, 1'b1, 4);
    c_resp_valid = 1'b1;
    c_resp_data  = 32'hDEADBEEF;
    tick();
    check_quiet("late_resp");
    check("late_rdata", rdata, 32'd0);
    c_resp_valid = 1'b0;

    // Handshake in the timeout cycle wins over the timeout
    run_txn(1'b0, 3'b001, 32'h106, 32'h0, 3, 4, 32'h80001234,
            32'h104, 4'b1100, 32'h0, 32'hFFFF8000, 1'b0, 5);
    // SH 0x102: half replicated into both lanes
    run_txn(1'b1, 3'b001, 32'h102, 32'h00001234, 1, 2, 32'h0,
            32'h100, 4'b1100, 32'h12341234, 32'hFFFF8000, 1'b0, 3);
    // LBU 0x101 -> byte 1 zero-extended
    run_txn(1'b0, 3'b100, 32'h101, 32'h0, 1, 2, 32'h0000F000,
            32'h100, 4'b0010, 32'h0, 32'h000000F0, 1'b0, 3);

    // Reset while in WAIT, together with a response: reset wins
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h300;
    tick();
    mem_read    = 1'b0;
    c_req_ready = 1'b1;
    #1;
    check("rst_req_cvalid", c_req_valid, 1'b1);
    tick();
    c_req_ready  = 1'b0;
    c_resp_valid = 1'b1;
    c_resp_data  = 32'hFFFFFFFF;
    reset        = 1'b1;
    #1;
    check("rst_wait_stall", stall, 1'b1);
    check("rst_wait_cvalid", c_req_valid, 1'b0);
    tick();
    reset        = 1'b0;
    c_resp_valid = 1'b0;
    #1;
    check_quiet("rst_wait");
    check("rst_wait_rdata", rdata, 32'd0);
    check("rst_wait_caddr", c_req_addr, 32'd0);
    check("rst_wait_be", c_req_be, 4'd0);
    check("rst_wait_we", c_req_we, 1'b0);
    check("rst_wait_cwd", c_req_wdata, 32'd0);

    // LW 0x200 after the abandoned transaction completes normally
    run_txn(1'b0, 3'b010, 32'h200, 32'h0, 1, 2, 32'h12345678,
            32'h200, 4'b1111, 32'h0, 32'h12345678, 1'b0, 3);
    // Timeout in WAIT (accepted, never answered)
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, 1, -1, 32'h0,
            32'h10, 4'b1111, 32'h0, 32'h0, 1'b1, 4);
    // SW 0x8: word passed through, all lanes enabled
    run_txn(1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 1, 2, 32'h0,
            32'h8, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 3);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
